// File: rtl/hdlc_tx_framer_pkg.sv
// Shared constants and state encoding for the HDLC transmit framer and its bit stuffer.
package hdlc_tx_framer_pkg;
   localparam logic [7:0] FLAG      = 8'h7E;
   localparam int         ABORT_LEN = 8;
   localparam int         STUFF_RUN = 5;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_OPEN  = 3'd1,
      ST_DATA  = 3'd2,
      ST_CLOSE = 3'd3,
      ST_ABORT = 3'd4
   } state_t;
endpackage

// File: rtl/hdlc_bit_stuffer.sv
// Counts consecutive ones on an HDLC bit stream and requests a zero after STUFF_RUN of them.
module hdlc_bit_stuffer
   import hdlc_tx_framer_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_clr,
   input  logic i_en,
   input  logic i_bit,
   output logic o_stuff,
   output logic o_near
);
   logic [2:0] r_ones;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_ones <= 3'd0;
      else if (i_clr)  r_ones <= 3'd0;
      else if (i_en)   r_ones <= i_bit ? r_ones + 3'd1 : 3'd0;
   end

   // o_near lets the framer see that the bit about to go out will trigger a stuff
   assign o_stuff = (r_ones == 3'(STUFF_RUN));
   assign o_near  = (r_ones == 3'(STUFF_RUN - 1));
endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: opening flags, bit-stuffed payload bytes, closing flag or abort, LSB first.
module hdlc_tx_framer
   import hdlc_tx_framer_pkg::*;
#(
   parameter int   NUM_OPEN = 1,
   parameter logic IDLE_BIT = 1'b1,
   parameter int   DBW      = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           inr,
   input  logic           trastart,
   input  logic [DBW-1:0] db,
   input  logic [7:0]     in_data,
   input  logic           in_vld,
   output logic           in_rdy,
   output logic           tx_bit,
   output logic           tx_en,
   output logic           busy,
   output logic           done,
   output logic           abort_err
);
   state_t         r_state;
   logic [7:0]     r_sh;
   logic [4:0]     r_bit_cnt;
   logic [DBW-1:0] r_db;
   logic [DBW-1:0] r_byte_cnt;
   logic           r_byte_done;
   logic           r_trastart_d;
   logic           r_tx_bit;
   logic           r_tx_en;
   logic           r_busy;
   logic           r_done;
   logic           r_abort_err;

   logic w_start, w_more, w_bit, w_stuff, w_near, w_pend;
   logic w_open_last, w_data_last, w_need;

   assign w_start     = trastart & ~r_trastart_d;
   assign w_more      = (r_byte_cnt != r_db);
   assign w_pend      = w_near & r_sh[0];
   assign w_open_last = (r_state == ST_OPEN) && (r_bit_cnt == 5'(8 * NUM_OPEN - 1));
   // A byte is finished on its 8th bit, or on the stuff bit that its 8th bit provoked
   assign w_data_last = (r_state == ST_DATA) &&
                        (w_stuff ? r_byte_done : ((r_bit_cnt == 5'd7) && !w_pend));
   assign w_need      = (w_open_last || w_data_last) && w_more;

   always_comb begin
      w_bit = r_sh[0];
      if ((r_state == ST_DATA) && w_stuff) w_bit = 1'b0;
      else if (r_state == ST_ABORT)        w_bit = 1'b1;
   end

   hdlc_bit_stuffer u_stuffer (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_clr   (inr || (r_state != ST_DATA)),
      .i_en    (r_state == ST_DATA),
      .i_bit   (w_bit),
      .o_stuff (w_stuff),
      .o_near  (w_near)
   );

   always_ff @(posedge clk) begin
      if (r_state == ST_IDLE) begin
         if (w_start) begin
            r_db <= db;
            r_sh <= FLAG;
         end
      end else if (w_need && in_vld) begin
         r_sh <= in_data;
      end else if (((r_state == ST_OPEN) && (r_bit_cnt[2:0] == 3'd7)) || w_data_last) begin
         r_sh <= FLAG;
      end else if (!((r_state == ST_DATA) && w_stuff)) begin
         r_sh <= {1'b0, r_sh[7:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_bit_cnt    <= 5'd0;
         r_byte_cnt   <= '0;
         r_byte_done  <= 1'b0;
         r_trastart_d <= 1'b0;
         r_tx_bit     <= IDLE_BIT;
         r_tx_en      <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_abort_err  <= 1'b0;
      end else if (inr) begin
         r_state      <= ST_IDLE;
         r_bit_cnt    <= 5'd0;
         r_byte_cnt   <= '0;
         r_byte_done  <= 1'b0;
         r_trastart_d <= 1'b0;
         r_tx_bit     <= IDLE_BIT;
         r_tx_en      <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_abort_err  <= 1'b0;
      end else begin
         r_trastart_d <= trastart;
         r_done       <= 1'b0;
         r_abort_err  <= 1'b0;
         r_tx_en      <= (r_state != ST_IDLE);
         r_tx_bit     <= (r_state == ST_IDLE) ? IDLE_BIT : w_bit;
         case (r_state)
            ST_IDLE: begin
               r_busy <= w_start;
               if (w_start) begin
                  r_state     <= ST_OPEN;
                  r_bit_cnt   <= 5'd0;
                  r_byte_cnt  <= '0;
                  r_byte_done <= 1'b0;
               end
            end
            ST_OPEN: r_bit_cnt <= r_bit_cnt + 5'd1;
            ST_DATA: begin
               if (!w_stuff) begin
                  if (r_bit_cnt == 5'd7) r_byte_done <= 1'b1;
                  else                   r_bit_cnt   <= r_bit_cnt + 5'd1;
               end
            end
            ST_CLOSE: begin
               r_bit_cnt <= r_bit_cnt + 5'd1;
               if (r_bit_cnt == 5'd7) begin
                  r_done  <= 1'b1;
                  r_state <= ST_IDLE;
               end
            end
            ST_ABORT: begin
               r_bit_cnt   <= r_bit_cnt + 5'd1;
               r_abort_err <= (r_bit_cnt == 5'd0);
               if (r_bit_cnt == 5'(ABORT_LEN - 1)) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
         // End of a flag run or byte: fetch the next byte, close, or abort on underrun
         if (w_open_last || w_data_last) begin
            r_bit_cnt   <= 5'd0;
            r_byte_done <= 1'b0;
            if (!w_more) begin
               r_state <= ST_CLOSE;
            end else if (in_vld) begin
               r_state    <= ST_DATA;
               r_byte_cnt <= r_byte_cnt + DBW'(1);
            end else begin
               r_state <= ST_ABORT;
            end
         end
      end
   end

   assign in_rdy    = w_need;
   assign tx_bit    = r_tx_bit;
   assign tx_en     = r_tx_en;
   assign busy      = r_busy;
   assign done      = r_done;
   assign abort_err = r_abort_err;
endmodule

// File: tb/tb_hdlc_tx_framer.sv
// Bench for hdlc_tx_framer: expected line bits queued from a reference framing model, compared as tx_en bits appear.
module tb_hdlc_tx_framer;
   localparam int DBW = 10;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           inr = 1'b0;
   logic           sel = 1'b0;
   logic           trastart = 1'b0;
   logic           in_vld = 1'b0;
   logic [DBW-1:0] db = '0;
   logic [7:0]     in_data = 8'h00;

   logic           a_start, a_vld, a_rdy, a_bit, a_en, a_busy, a_done, a_abort;
   logic           b_start, b_vld, b_rdy, b_bit, b_en, b_busy, b_done, b_abort;
   logic [DBW-1:0] a_db, b_db;
   logic [7:0]     a_data, b_data;
   logic           obs_rdy, obs_bit, obs_en, obs_busy, obs_done, obs_abort;

   assign a_start = sel ? 1'b0 : trastart;
   assign a_vld   = sel ? 1'b0 : in_vld;
   assign a_db    = sel ? '0 : db;
   assign a_data  = sel ? 8'h00 : in_data;
   assign b_start = sel ? trastart : 1'b0;
   assign b_vld   = sel ? in_vld : 1'b0;
   assign b_db    = sel ? db : '0;
   assign b_data  = sel ? in_data : 8'h00;

   assign obs_rdy   = sel ? b_rdy   : a_rdy;
   assign obs_bit   = sel ? b_bit   : a_bit;
   assign obs_en    = sel ? b_en    : a_en;
   assign obs_busy  = sel ? b_busy  : a_busy;
   assign obs_done  = sel ? b_done  : a_done;
   assign obs_abort = sel ? b_abort : a_abort;

   hdlc_tx_framer #(.NUM_OPEN(1), .IDLE_BIT(1'b1), .DBW(DBW)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .inr(inr), .trastart(a_start), .db(a_db),
      .in_data(a_data), .in_vld(a_vld), .in_rdy(a_rdy), .tx_bit(a_bit),
      .tx_en(a_en), .busy(a_busy), .done(a_done), .abort_err(a_abort)
   );

   hdlc_tx_framer #(.NUM_OPEN(2), .IDLE_BIT(1'b1), .DBW(DBW)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .inr(inr), .trastart(b_start), .db(b_db),
      .in_data(b_data), .in_vld(b_vld), .in_rdy(b_rdy), .tx_bit(b_bit),
      .tx_en(b_en), .busy(b_busy), .done(b_done), .abort_err(b_abort)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic        exp_q[$];
   logic [7:0]  src_q[$];
   logic [63:0] cap;
   int          m_ones;
   int          nb, nr, da, aa;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic exp_flag();
      logic [7:0] f;
      f = 8'h7E;
      for (int i = 0; i < 8; i++) exp_q.push_back(f[i]);
      m_ones = 0;
   endtask

   task automatic exp_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(b[i]);
         if (b[i]) m_ones++;
         else      m_ones = 0;
         if (m_ones == 5) begin
            exp_q.push_back(1'b0);
            m_ones = 0;
         end
      end
   endtask

   task automatic exp_abort();
      for (int i = 0; i < 8; i++) exp_q.push_back(1'b1);
   endtask

   // Starts a frame, feeds src_q on the handshake and scores every tx_en bit; returns at idle
   task automatic run_frame(input int dbv, input bit toggle, output int nbits, output int nrdy,
                            output int done_at, output int abort_at);
      bit seen_en;
      bit fin;
      nbits = 0; nrdy = 0; done_at = 0; abort_at = 0;
      seen_en = 1'b0; fin = 1'b0; cap = '0;
      db = dbv[DBW-1:0];
      trastart = 1'b1;
      for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
         in_vld  = (src_q.size() > 0);
         in_data = in_vld ? src_q[0] : 8'h00;
         if (obs_rdy) begin
            nrdy++;
            if (in_vld) void'(src_q.pop_front());
         end
         if (cyc == 2) trastart = 1'b0;
         if (toggle && (cyc == 12 || cyc == 14)) trastart = 1'b1;
         if (toggle && (cyc == 13 || cyc == 15)) trastart = 1'b0;
         @(negedge clk);
         if (obs_en) begin
            nbits++;
            seen_en = 1'b1;
            cap = {cap[62:0], obs_bit};
            if (exp_q.size() == 0) check("extra_bit", 64'(obs_bit), 64'h2);
            else                   check($sformatf("bit%0d", nbits), 64'(obs_bit), 64'(exp_q.pop_front()));
         end
         if (obs_done)  done_at  = nbits;
         if (obs_abort) abort_at = nbits;
         if (seen_en && !obs_en && !obs_busy) fin = 1'b1;
      end
      in_vld = 1'b0;
      check("frame_end", 64'(fin), 64'd1);
      check("bits_left", 64'(exp_q.size()), 64'd0);
      check("idle_bit", 64'(obs_bit), 64'd1);
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_bit"},   64'(obs_bit),   64'd1);
      check({tag, "_en"},    64'(obs_en),    64'd0);
      check({tag, "_rdy"},   64'(obs_rdy),   64'd0);
      check({tag, "_busy"},  64'(obs_busy),  64'd0);
      check({tag, "_done"},  64'(obs_done),  64'd0);
      check({tag, "_abort"}, 64'(obs_abort), 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("post_rst");

      // Single all-ones byte
      src_q = '{8'hFF, 8'hFF};
      exp_flag(); exp_byte(8'hFF); exp_flag();
      run_frame(1, 1'b0, nb, nr, da, aa);
      check("t1_bits", 64'(nb), 64'd25);
      check("t1_done_at", 64'(da), 64'd25);
      check("t1_rdy", 64'(nr), 64'd1);
      check("t1_stream", 64'(cap[24:0]), 64'(25'b0111111011111011101111110));
      check("t1_unused", 64'(src_q.size()), 64'd1);
      check("t1_abort", 64'(aa), 64'd0);
      src_q.delete();

      // Two bytes, each needing a stuff bit
      src_q = '{8'h7C, 8'h1F};
      exp_flag(); exp_byte(8'h7C); exp_byte(8'h1F); exp_flag();
      run_frame(2, 1'b0, nb, nr, da, aa);
      check("t2_bits", 64'(nb), 64'd34);
      check("t2_rdy", 64'(nr), 64'd2);
      check("t2_done_at", 64'(da), 64'd34);
      check("t2_stream", 64'(cap[33:0]), 64'(34'b0111111000111110011111000001111110));

      // Empty frame
      exp_flag(); exp_flag();
      run_frame(0, 1'b0, nb, nr, da, aa);
      check("t3_bits", 64'(nb), 64'd16);
      check("t3_rdy", 64'(nr), 64'd0);
      check("t3_done_at", 64'(da), 64'd16);
      check("t3_stream", 64'(cap[15:0]), 64'(16'b0111111001111110));

      // Underrun before the second byte
      src_q = '{8'hA5};
      exp_flag(); exp_byte(8'hA5); exp_abort();
      run_frame(3, 1'b0, nb, nr, da, aa);
      check("t4_bits", 64'(nb), 64'd24);
      check("t4_abort_at", 64'(aa), 64'd17);
      check("t4_done", 64'(da), 64'd0);
      check("t4_rdy", 64'(nr), 64'd2);
      check("t4_busy", 64'(obs_busy), 64'd0);

      // Synchronous clear mid-payload, then a clean frame
      db = 10'd2; in_vld = 1'b1; in_data = 8'hFF; trastart = 1'b1;
      repeat (2) @(negedge clk);
      trastart = 1'b0;
      repeat (10) @(negedge clk);
      check("t5_mid_en", 64'(obs_en), 64'd1);
      check("t5_mid_busy", 64'(obs_busy), 64'd1);
      inr = 1'b1; in_vld = 1'b0;
      @(negedge clk);
      check_reset_outputs("t5_inr");
      inr = 1'b0;
      @(negedge clk);
      src_q = '{8'h3C};
      exp_flag(); exp_byte(8'h3C); exp_flag();
      run_frame(1, 1'b0, nb, nr, da, aa);
      check("t5_inr_bits", 64'(nb), 64'd24);
      check("t5_inr_done_at", 64'(da), 64'd24);

      // Asynchronous reset mid-payload, then a frame whose last bit provokes a stuff
      db = 10'd2; in_vld = 1'b1; in_data = 8'hFF; trastart = 1'b1;
      repeat (2) @(negedge clk);
      trastart = 1'b0;
      repeat (10) @(negedge clk);
      check("t5b_mid_en", 64'(obs_en), 64'd1);
      rst_n = 1'b0; in_vld = 1'b0;
      @(negedge clk);
      check_reset_outputs("t5_rstn");
      rst_n = 1'b1;
      @(negedge clk);
      src_q = '{8'hF8};
      exp_flag(); exp_byte(8'hF8); exp_flag();
      run_frame(1, 1'b0, nb, nr, da, aa);
      check("t5_rstn_bits", 64'(nb), 64'd25);
      check("t5_rstn_rdy", 64'(nr), 64'd1);

      // Random payloads
      for (int f = 0; f < 2; f++) begin
         logic [7:0] b;
         src_q.delete();
         exp_flag();
         for (int k = 0; k < 4; k++) begin
            b = 8'($urandom | $urandom);
            src_q.push_back(b);
            exp_byte(b);
         end
         exp_flag();
         run_frame(4, 1'b0, nb, nr, da, aa);
         check("rnd_rdy", 64'(nr), 64'd4);
         check("rnd_done", 64'(da), 64'(nb));
      end

      // Two opening flags, restart attempts during the frame
      @(negedge clk);
      sel = 1'b1;
      @(negedge clk);
      src_q = '{8'h00};
      exp_flag(); exp_flag(); exp_byte(8'h00); exp_flag();
      run_frame(1, 1'b1, nb, nr, da, aa);
      check("t6_bits", 64'(nb), 64'd32);
      check("t6_done_at", 64'(da), 64'd32);
      check("t6_rdy", 64'(nr), 64'd1);
      repeat (3) @(negedge clk);
      check("t6_no_restart", 64'(obs_en), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
